conv_scheduler: RTL

CONV_SCHEDULER -- requirements
Module: conv_scheduler

---
 rtl/conv_scheduler.sv | 110 +++++++++++
 1 files changed

// File: rtl/conv_scheduler.sv
// Window scheduler: walks filter origins over the input map, hands each window
// to a shared conv engine and writes results back. Optional: CONV_SCHEDULER_RELU_EN.
module conv_scheduler #(
    parameter  int input_size  = 7,
    parameter  int filter_size = 3,
    parameter  int stride      = 2,
    localparam int OUT  = ((input_size - filter_size) / stride) + 1,
    localparam int NWIN = OUT * OUT,
    localparam int CW   = (input_size > 1) ? $clog2(input_size) : 1,
    localparam int IW   = (NWIN > 1) ? $clog2(NWIN) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] win_row,
    output logic [CW-1:0] win_col,
    output logic          eng_valid,
    input  logic          eng_ready,
    input  logic          res_valid,
    input  logic [31:0]   res_data,
    output logic          out_we,
    output logic [IW-1:0] out_addr,
    output logic [31:0]   out_data
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ISSUE = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] FIN   = 3'd4;

    localparam int LIM = input_size - filter_size;

    logic [2:0]    state;
    logic [IW-1:0] index;
    logic [31:0]   data_q;
    logic [31:0]   res_proc;
    logic          last;
    logic          col_wrap;

`ifdef CONV_SCHEDULER_RELU_EN
    assign res_proc = res_data[31] ? 32'd0 : res_data;
`else
    assign res_proc = res_data;
`endif

    assign last     = (index == IW'(NWIN - 1));
    assign col_wrap = (32'(win_col) + 32'(stride)) > 32'(LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            win_row <= '0;
            win_col <= '0;
            index   <= '0;
            data_q  <= '0;
        end else if (abort) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= ISSUE;
                        win_row <= '0;
                        win_col <= '0;
                        index   <= '0;
                    end
                end
                ISSUE: begin
                    if (eng_ready) state <= WAIT;
                end
                WAIT: begin
                    if (res_valid) begin
                        data_q <= res_proc;
                        state  <= WRITE;
                    end
                end
                WRITE: begin
                    if (last) begin
                        state <= FIN;
                    end else begin
                        // raster order: step right, wrap to next window row
                        if (col_wrap) begin
                            win_col <= '0;
                            win_row <= win_row + CW'(stride);
                        end else begin
                            win_col <= win_col + CW'(stride);
                        end
                        index <= index + 1'b1;
                        state <= ISSUE;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // abort suppresses strobes in the cycle it is raised
    assign busy      = (state != IDLE);
    assign done      = (state == FIN) && !abort;
    assign eng_valid = (state == ISSUE) && !abort;
    assign out_we    = (state == WRITE) && !abort;
    assign out_addr  = index;
    assign out_data  = data_q;

endmodule
